// File: rtl/expr_result_misr.sv
// expr_result_misr
//
// Capture stage for the packed result bus of a generated expression block.
// One result word is absorbed per handshake into a multiple-input signature
// register (MISR). After a programmed number of words the block stops and
// presents the final signature, so a whole run can be compared against a
// golden model with one comparison.
//
// Optional feature: define EXPR_MISR_CHECK_EN to add the `golden` input and
// the registered `pass` output (final signature == golden).
//
// Ports:
//   clk          in   single clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   one-cycle pulse; loads seed/count (accepted in IDLE or DONE)
//   seed         in   W     initial signature, sampled on accepted start
//   num_samples  in   CNTW  words to absorb, sampled on accepted start
//   y_in         in   W     result word
//   in_valid     in   y_in valid this cycle
//   in_ready     out  registered; high exactly while in RUN
//   signature    out  W     current MISR contents
//   sample_cnt   out  CNTW  words absorbed since last start
//   busy         out  state is RUN
//   done         out  state is DONE
//   golden       in   W     expected final signature (EXPR_MISR_CHECK_EN only)
//   pass         out  final signature matched golden (EXPR_MISR_CHECK_EN only)

module expr_result_misr #(
    parameter int unsigned W    = 90,
    parameter logic [W-1:0] POLY = 90'h200_0000_0000_0000_0000_0041,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [W-1:0]    seed,
    input  logic [CNTW-1:0] num_samples,
    input  logic [W-1:0]    y_in,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [W-1:0]    signature,
    output logic [CNTW-1:0] sample_cnt,
    output logic            busy,
`ifdef EXPR_MISR_CHECK_EN
    output logic            done,
    input  logic [W-1:0]    golden,
    output logic            pass
`else
    output logic            done
`endif
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e          state_q;
    logic [CNTW-1:0] target_q;
    logic [W-1:0]    misr_next;
    logic [CNTW-1:0] cnt_next;
    logic            accept;

    // Galois-style shift: feedback taps applied when the MSB falls out.
    always_comb begin
        misr_next = {signature[W-2:0], 1'b0} ^ (signature[W-1] ? POLY : '0) ^ y_in;
        cnt_next  = sample_cnt + 1'b1;
        accept    = in_valid && in_ready;
    end

    // Single FSM block; busy/done/in_ready are registered alongside the state
    // so none of them has a combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            signature  <= '0;
            sample_cnt <= '0;
            target_q   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_ready   <= 1'b0;
`ifdef EXPR_MISR_CHECK_EN
            pass       <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        signature  <= seed;
                        sample_cnt <= '0;
                        target_q   <= num_samples;
                        if (num_samples == '0) begin
                            // Nothing to absorb: the seed is already final.
                            state_q  <= StDone;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
`ifdef EXPR_MISR_CHECK_EN
                            pass     <= (seed == golden);
`endif
                        end else begin
                            state_q  <= StRun;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            in_ready <= 1'b1;
`ifdef EXPR_MISR_CHECK_EN
                            pass     <= 1'b0;
`endif
                        end
                    end
                end
                StRun: begin
                    // start is ignored here, including on the final accept.
                    if (accept) begin
                        signature  <= misr_next;
                        sample_cnt <= cnt_next;
                        if (cnt_next == target_q) begin
                            state_q  <= StDone;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            in_ready <= 1'b0;
`ifdef EXPR_MISR_CHECK_EN
                            pass     <= (misr_next == golden);
`endif
                        end
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
